// File: rtl/cpi_pkg.sv
// Shared CPI definitions used by the agent link transmitter and the fabric manager.
package cpi_pkg;

    localparam int CPI_HDR_W = 129;
    localparam int CPI_PID_W = 4;
    localparam int CPI_REQ_W = CPI_PID_W + CPI_HDR_W;

    typedef enum logic [1:0] {
        DISCONNECTED  = 2'd0,
        CONNECTING    = 2'd1,
        CONNECTED     = 2'd2,
        DISCONNECTING = 2'd3
    } link_state_e;

    typedef struct packed {
        logic [CPI_PID_W-1:0] pid;
        logic [CPI_HDR_W-1:0] header;
    } cpi_req_t;

endpackage

// File: rtl/cpi_hdr_fifo.sv
// Synchronous request-header FIFO with full/empty flags and a flush that empties it in one cycle.
module cpi_hdr_fifo
    import cpi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [CPI_REQ_W-1:0] push_data,
    input  logic                 pop,
    output logic [CPI_REQ_W-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    cpi_req_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpi_agent_link_tx.sv
// Agent-side CPI link transmitter: connect/disconnect FSM, credit-controlled A2F request send.
// Optional connect timeout enabled by defining CPI_CONN_TIMEOUT_EN.
//
//  state         | meaning
//  DISCONNECTED  | link down, txcon_req low
//  CONNECTING    | txcon_req high, waiting for rxcon_ack
//  CONNECTED     | link up, headers sent under credit control
//  DISCONNECTING | txcon_req dropped, waiting for ack to fall or a nack
module cpi_agent_link_tx
    import cpi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CRD_INIT    = 8,
    parameter int BACKOFF_CYC = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 agt_clk,
    input  logic                 agt_rst,
    input  logic                 link_en,
    output logic [1:0]           link_state,
    output logic                 conn_timeout,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CPI_PID_W-1:0] req_protocol_id,
    input  logic [CPI_HDR_W-1:0] req_header,
    output logic                 a2f_txcon_req,
    input  logic                 a2f_rxcon_ack,
    input  logic                 a2f_rxdiscon_nack,
    input  logic                 a2f_rx_empty,
    output logic                 a2f_fatal,
    output logic                 a2f_req_is_valid,
    output logic [CPI_PID_W-1:0] a2f_req_protocol_id,
    output logic [CPI_HDR_W-1:0] a2f_req_header,
    input  logic                 a2f_req_crd_rtn
);

    // One counter serves both the disconnect backoff and the connect timeout.
    localparam int CNT_MAX = (BACKOFF_CYC > TIMEOUT_CYC) ? BACKOFF_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [7:0] CRD_MAX = 8'(CRD_INIT);

    link_state_e          state;
    logic [7:0]           credits;
    logic [CNT_W-1:0]     cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 in_link;
    logic                 send_raw;
    logic                 send;
    logic                 crd_ovf;
    logic                 fatal_now;
    logic [CPI_REQ_W-1:0] head;
    cpi_req_t             head_s;

    assign head_s     = head;
    assign link_state = state;
    assign req_ready  = !fifo_full && (state == CONNECTED);
    assign push       = req_valid && req_ready;
    assign in_link    = (state == CONNECTED) || (state == DISCONNECTING);
    assign send_raw   = (state == CONNECTED) && !fifo_empty && (credits != 8'd0);
    assign crd_ovf    = in_link && a2f_req_crd_rtn && !send_raw && (credits == CRD_MAX);
    assign fatal_now  = ((state == CONNECTED) && !a2f_rxcon_ack) || crd_ovf
                        || (a2f_rxdiscon_nack && (state != DISCONNECTING));
    assign send       = send_raw && !fatal_now;

    cpi_hdr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (agt_clk),
        .rst       (agt_rst),
        .flush     (fatal_now),
        .push      (push),
        .push_data ({req_protocol_id, req_header}),
        .pop       (send),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef CPI_CONN_TIMEOUT_EN
    logic timeout_q;
    logic retry_blk;
    assign conn_timeout = timeout_q;
`else
    assign conn_timeout = 1'b0;
`endif

    always_ff @(posedge agt_clk) begin
        if (agt_rst) begin
            state               <= DISCONNECTED;
            credits             <= 8'd0;
            cnt                 <= '0;
            a2f_txcon_req       <= 1'b0;
            a2f_fatal           <= 1'b0;
            a2f_req_is_valid    <= 1'b0;
            a2f_req_protocol_id <= '0;
            a2f_req_header      <= '0;
`ifdef CPI_CONN_TIMEOUT_EN
            timeout_q           <= 1'b0;
            retry_blk           <= 1'b0;
`endif
        end else begin
`ifdef CPI_CONN_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            a2f_req_is_valid <= send;
            if (send) begin
                a2f_req_protocol_id <= head_s.pid;
                a2f_req_header      <= head_s.header;
            end
            if (in_link) begin
                case ({send, a2f_req_crd_rtn})
                    2'b10:   credits <= credits - 8'd1;
                    2'b01:   credits <= credits + 8'd1;
                    default: credits <= credits;
                endcase
            end

            if (fatal_now) begin
                a2f_fatal     <= 1'b1;
                state         <= DISCONNECTED;
                credits       <= 8'd0;
                cnt           <= '0;
                a2f_txcon_req <= 1'b0;
            end else begin
                case (state)
                    DISCONNECTED: begin
`ifdef CPI_CONN_TIMEOUT_EN
                        if (!link_en) retry_blk <= 1'b0;
                        if (link_en && !a2f_fatal && !retry_blk) begin
                            state         <= CONNECTING;
                            a2f_txcon_req <= 1'b1;
                            cnt           <= CNT_W'(TIMEOUT_CYC - 1);
                        end
`else
                        if (link_en && !a2f_fatal) begin
                            state         <= CONNECTING;
                            a2f_txcon_req <= 1'b1;
                        end
`endif
                    end
                    CONNECTING: begin
                        if (a2f_rxcon_ack) begin
                            state   <= CONNECTED;
                            credits <= CRD_MAX;
                            cnt     <= '0;
                        end
`ifdef CPI_CONN_TIMEOUT_EN
                        else if (cnt == '0) begin
                            state         <= DISCONNECTED;
                            a2f_txcon_req <= 1'b0;
                            timeout_q     <= 1'b1;
                            retry_blk     <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
`endif
                    end
                    CONNECTED: begin
                        // A push in the same cycle would strand a header, so it blocks the exit.
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (!link_en && fifo_empty && !push
                                     && (credits == CRD_MAX) && a2f_rx_empty) begin
                            state         <= DISCONNECTING;
                            a2f_txcon_req <= 1'b0;
                        end
                    end
                    DISCONNECTING: begin
                        if (a2f_rxdiscon_nack && a2f_rxcon_ack) begin
                            state         <= CONNECTED;
                            a2f_txcon_req <= 1'b1;
                            cnt           <= CNT_W'(BACKOFF_CYC - 1);
                        end else if (!a2f_rxcon_ack) begin
                            state   <= DISCONNECTED;
                            credits <= 8'd0;
                        end
                    end
                    default: state <= DISCONNECTED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpi_agent_link_tx.sv
// Directed bench for cpi_agent_link_tx: connect, credit-limited burst, disconnect nack/backoff,
// fatal handling and the connect-timeout behaviour of whichever build is compiled.
module tb_cpi_agent_link_tx;
    import cpi_pkg::*;

    logic         agt_clk = 1'b0;
    logic         agt_rst = 1'b1;
    logic         link_en = 1'b0;
    logic [1:0]   link_state;
    logic         conn_timeout;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_protocol_id = '0;
    logic [128:0] req_header = '0;
    logic         a2f_txcon_req;
    logic         a2f_rxcon_ack = 1'b0;
    logic         a2f_rxdiscon_nack = 1'b0;
    logic         a2f_rx_empty = 1'b1;
    logic         a2f_fatal;
    logic         a2f_req_is_valid;
    logic [3:0]   a2f_req_protocol_id;
    logic [128:0] a2f_req_header;
    logic         a2f_req_crd_rtn = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int sent = 0;
    int to_cnt = 0;
    int idx = 0;
    logic [132:0] exp_q [$];

    cpi_agent_link_tx dut (
        .agt_clk             (agt_clk),
        .agt_rst             (agt_rst),
        .link_en             (link_en),
        .link_state          (link_state),
        .conn_timeout        (conn_timeout),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_protocol_id     (req_protocol_id),
        .req_header          (req_header),
        .a2f_txcon_req       (a2f_txcon_req),
        .a2f_rxcon_ack       (a2f_rxcon_ack),
        .a2f_rxdiscon_nack   (a2f_rxdiscon_nack),
        .a2f_rx_empty        (a2f_rx_empty),
        .a2f_fatal           (a2f_fatal),
        .a2f_req_is_valid    (a2f_req_is_valid),
        .a2f_req_protocol_id (a2f_req_protocol_id),
        .a2f_req_header      (a2f_req_header),
        .a2f_req_crd_rtn     (a2f_req_crd_rtn)
    );

    always #5 agt_clk = ~agt_clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge agt_clk);
        #1;
    endtask

    function automatic logic [132:0] gen(input int i);
        logic [31:0] v;
        v = i;
        return {v[3:0] ^ 4'h5, v[0], 64'hC0DE_0000_0000_0000 | 64'(v), ~{32'h0, v}};
    endfunction

    // Drive n headers, each accepted only when req_ready was high before the edge.
    task automatic push_n(input int n);
        int pushed;
        int guard;
        logic rdy;
        logic [132:0] g;
        pushed = 0;
        guard  = 0;
        while (pushed < n && guard < 200) begin
            g = gen(idx);
            req_valid       = 1'b1;
            req_protocol_id = g[132:129];
            req_header      = g[128:0];
            rdy = req_ready;
            step();
            if (rdy) begin
                exp_q.push_back(g);
                idx++;
                pushed++;
            end
            guard++;
        end
        req_valid = 1'b0;
        chk("push_count", 160'(pushed), 160'(n));
    endtask

    task automatic crd_pulses(input int n);
        repeat (n) begin
            a2f_req_crd_rtn = 1'b1;
            step();
        end
        a2f_req_crd_rtn = 1'b0;
    endtask

    always @(negedge agt_clk) begin
        if (!agt_rst && conn_timeout) to_cnt++;
        if (!agt_rst && a2f_req_is_valid) begin
            sent++;
            if (exp_q.size() == 0) begin
                chk("a2f_unexpected", 160'd1, 160'd0);
            end else begin
                chk("a2f_data", 160'({a2f_req_protocol_id, a2f_req_header}), 160'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int snap;
        step(3);
        chk("rst_state",  160'(link_state),       160'(DISCONNECTED));
        chk("rst_txcon",  160'(a2f_txcon_req),    160'd0);
        chk("rst_fatal",  160'(a2f_fatal),        160'd0);
        chk("rst_valid",  160'(a2f_req_is_valid), 160'd0);
        chk("rst_ready",  160'(req_ready),        160'd0);
        chk("rst_tmo",    160'(conn_timeout),     160'd0);
        agt_rst = 1'b0;
        step();

        // Connect with ack three cycles after txcon_req.
        link_en = 1'b1;
        step();
        chk("conn_state", 160'(link_state),    160'(CONNECTING));
        chk("conn_txcon", 160'(a2f_txcon_req), 160'd1);
        step(2);
        chk("conn_wait",  160'(link_state),    160'(CONNECTING));
        a2f_rxcon_ack = 1'b1;
        step();
        chk("conn_up",    160'(link_state),    160'(CONNECTED));
        chk("conn_ready", 160'(req_ready),     160'd1);

        // Burst of 10 with 8 credits; first header shows the empty-FIFO latency.
        push_n(1);
        chk("lat_c1", 160'(a2f_req_is_valid), 160'd0);
        push_n(9);
        step(4);
        chk("burst_sent",  160'(sent),      160'd8);
        chk("burst_ready", 160'(req_ready), 160'd1);
        crd_pulses(2);
        step(4);
        chk("crd2_sent", 160'(sent), 160'd10);

        // Credits now 0: four pushes fill the FIFO.
        push_n(4);
        chk("full_ready", 160'(req_ready), 160'd0);
        step(3);
        chk("full_hold",  160'(sent),      160'd10);
        // Returns held for 4 cycles, three of them coincident with a send.
        crd_pulses(4);
        step(4);
        chk("coinc_sent", 160'(sent), 160'd14);
        push_n(1);
        step(3);
        chk("zero_hold",  160'(sent), 160'd14);
        crd_pulses(9);
        step(3);
        chk("refill_sent", 160'(sent), 160'd15);

        // Disconnect, nack, backoff, then ack falls.
        link_en = 1'b0;
        step();
        chk("disc_state", 160'(link_state),    160'(DISCONNECTING));
        chk("disc_txcon", 160'(a2f_txcon_req), 160'd0);
        a2f_rxdiscon_nack = 1'b1;
        step();
        a2f_rxdiscon_nack = 1'b0;
        chk("nack_state", 160'(link_state),    160'(CONNECTED));
        chk("nack_txcon", 160'(a2f_txcon_req), 160'd1);
        step(15);
        chk("backoff_hold", 160'(a2f_txcon_req), 160'd1);
        step();
        chk("backoff_done", 160'(a2f_txcon_req), 160'd0);
        chk("backoff_st",   160'(link_state),    160'(DISCONNECTING));
        a2f_rxcon_ack = 1'b0;
        step();
        chk("down_state", 160'(link_state), 160'(DISCONNECTED));
        chk("down_fatal", 160'(a2f_fatal),  160'd0);

        // Fatal: ack drops in CONNECTED with 2 headers queued.
        link_en = 1'b1;
        step();
        a2f_rxcon_ack = 1'b1;
        step();
        chk("re_conn", 160'(link_state), 160'(CONNECTED));
        snap = sent;
        push_n(8);
        push_n(2);
        step(3);
        chk("fat_pre_sent", 160'(sent - snap), 160'd8);
        a2f_rxcon_ack = 1'b0;
        step();
        chk("fat_flag",  160'(a2f_fatal),     160'd1);
        chk("fat_state", 160'(link_state),    160'(DISCONNECTED));
        chk("fat_txcon", 160'(a2f_txcon_req), 160'd0);
        chk("fat_ready", 160'(req_ready),     160'd0);
        a2f_rxcon_ack = 1'b1;
        step(5);
        chk("fat_noconn", 160'(link_state),  160'(DISCONNECTED));
        chk("fat_sticky", 160'(a2f_fatal),   160'd1);
        chk("fat_flush",  160'(sent - snap), 160'd8);
        a2f_rxcon_ack = 1'b0;
        agt_rst = 1'b1;
        step(2);
        agt_rst = 1'b0;
        exp_q.delete();
        chk("rst_clr_fatal", 160'(a2f_fatal), 160'd0);

        // Credit overflow: a return with all credits home is fatal.
        step();
        chk("ovf_conn0", 160'(link_state), 160'(CONNECTING));
        a2f_rxcon_ack = 1'b1;
        step();
        chk("ovf_conn", 160'(link_state), 160'(CONNECTED));
        crd_pulses(1);
        chk("ovf_fatal", 160'(a2f_fatal),  160'd1);
        chk("ovf_state", 160'(link_state), 160'(DISCONNECTED));
        a2f_rxcon_ack = 1'b0;
        link_en = 1'b0;
        agt_rst = 1'b1;
        step(2);
        agt_rst = 1'b0;
        step();

        // Connect attempt with no ack.
        link_en = 1'b1;
        step();
        chk("tmo_start", 160'(link_state), 160'(CONNECTING));
`ifdef CPI_CONN_TIMEOUT_EN
        step(255);
        chk("tmo_pre",   160'(link_state),    160'(CONNECTING));
        chk("tmo_pre_p", 160'(conn_timeout),  160'd0);
        step();
        chk("tmo_pulse", 160'(conn_timeout),  160'd1);
        chk("tmo_txcon", 160'(a2f_txcon_req), 160'd0);
        chk("tmo_state", 160'(link_state),    160'(DISCONNECTED));
        step();
        chk("tmo_1cyc",  160'(conn_timeout),  160'd0);
        step(3);
        chk("tmo_noretry", 160'(link_state),  160'(DISCONNECTED));
        chk("tmo_count", 160'(to_cnt), 160'd1);
        link_en = 1'b0;
        step();
        link_en = 1'b1;
        step();
        chk("tmo_retry", 160'(link_state), 160'(CONNECTING));
`else
        step(300);
        chk("notmo_state", 160'(link_state),    160'(CONNECTING));
        chk("notmo_txcon", 160'(a2f_txcon_req), 160'd1);
        chk("notmo_count", 160'(to_cnt),        160'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
